// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the nibble-serial ALU arbiter.
//   ArbState : arbiter FSM encoding, also exported on the debug port
//   AluJob   : operand bundle captured from the winning requester
//   NIB_*    : loop_nibbles_number encodings understood by the ALU
package alu_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    RUN      = 3'd2,
    COMPLETE = 3'd3,
    ERR      = 3'd4
  } ArbState;

  // Operand width of the ALU datapath; the arbiter WIDTH must match it.
  localparam int unsigned ALU_W = 32;

  typedef struct packed {
    logic [ALU_W-1:0] w1;
    logic [ALU_W-1:0] w2;
    logic [ALU_W-1:0] preinit;
    logic [2:0]       nibbles;
    logic             neg;
  } AluJob;

  localparam logic [2:0] NIB_INCREMENT = 3'd0;
  localparam logic [2:0] NIB_8         = 3'd1;
  localparam logic [2:0] NIB_12        = 3'd2;
  localparam logic [2:0] NIB_16        = 3'd3;
  localparam logic [2:0] NIB_24        = 3'd5;
  localparam logic [2:0] NIB_32        = 3'd7;

endpackage

// File: rtl/nibble_alu_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_owner : index of the most recently served requester
//   owner      : index of the winner (valid when any=1)
//   owner_oh   : one-hot winner
//   any        : at least one request is pending
// The scan starts at last_owner+1 and wraps, so the previous owner has the
// lowest priority.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [IDX_W-1:0] owner,
  output logic [N_REQ-1:0] owner_oh,
  output logic             any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    owner    = '0;
    owner_oh = '0;
    any      = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      // modulo N_REQ without a divider: sum never reaches 2*N_REQ
      sum = {1'b0, last_owner} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any            = 1'b1;
        owner          = cand;
        owner_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nibble_alu_arbiter.sv
// Shares one nibble-serial ALU between N_REQ job sources.
//   clk, rst_n            : clock, synchronous active-low reset
//   req*                  : per-requester job request and operands
//   gnt, done, result     : one-hot grant, one-cycle done pulse, latched result
//   err                   : sticky watchdog error (ALU never dropped busy)
//   alu_*                 : registered operands / permission to the ALU,
//                           busy and result back from it
//   dbg_state             : current FSM state
// Handshake: a requester raises req[i] with stable operands and holds it until
// done[i]; operands are captured when the job is picked in IDLE and frozen
// until COMPLETE, so later changes to req_* or dropping req do not affect the
// running job. result is valid in the done cycle and held until the next one.
module nibble_alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0][WIDTH-1:0]  req_w1,
  input  logic [N_REQ-1:0][WIDTH-1:0]  req_w2,
  input  logic [N_REQ-1:0][WIDTH-1:0]  req_preinit,
  input  logic [N_REQ-1:0][2:0]        req_nibbles,
  input  logic [N_REQ-1:0]             req_neg,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             done,
  output logic [WIDTH-1:0]             result,
  output logic                         err,
  output logic                         alu_perm_to_count,
  output logic [WIDTH-1:0]             alu_w1,
  output logic [WIDTH-1:0]             alu_w2,
  output logic [WIDTH-1:0]             alu_preinit_result,
  output logic [2:0]                   loop_nibbles_number,
  output logic                         word2_is_signed_and_negative,
  input  logic                         alu_busy,
  input  logic [WIDTH-1:0]             alu_result,
  output ArbState                      dbg_state
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_MAX     = WD_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

  ArbState          state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             perm_q, perm_d;
  AluJob            job_q, job_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;

  logic [IDX_W-1:0] pick_owner;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_any;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner_q),
    .owner      (pick_owner),
    .owner_oh   (pick_oh),
    .any        (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    result_d     = result_q;
    err_d        = err_q;
    perm_d       = perm_q;
    job_d        = job_q;
    wdog_d       = wdog_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d       = pick_owner;
          job_d.w1      = req_w1[pick_owner];
          job_d.w2      = req_w2[pick_owner];
          job_d.preinit = req_preinit[pick_owner];
          job_d.nibbles = req_nibbles[pick_owner];
          job_d.neg     = req_neg[pick_owner];
          // grant and permission are visible from the LAUNCH cycle on
          gnt_d         = pick_oh;
          perm_d        = 1'b1;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        wdog_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (!alu_busy) begin
          result_d = alu_result;
          perm_d   = 1'b0;
          done_d   = gnt_q;
          state_d  = COMPLETE;
        end else if (wdog_q == WD_MAX) begin
          perm_d  = 1'b0;
          gnt_d   = '0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      COMPLETE: begin
        gnt_d        = '0;
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      ERR: begin
        // terminal until reset; requests are ignored
        state_d = ERR;
      end
      default: begin
        gnt_d   = '0;
        perm_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RESET;
      gnt_q        <= '0;
      done_q       <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      perm_q       <= 1'b0;
      job_q        <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      result_q     <= result_d;
      err_q        <= err_d;
      perm_q       <= perm_d;
      job_q        <= job_d;
      wdog_q       <= wdog_d;
    end
  end

  assign gnt                          = gnt_q;
  assign done                         = done_q;
  assign result                       = result_q;
  assign err                          = err_q;
  assign alu_perm_to_count            = perm_q;
  assign alu_w1                       = job_q.w1;
  assign alu_w2                       = job_q.w2;
  assign alu_preinit_result           = job_q.preinit;
  assign loop_nibbles_number          = job_q.nibbles;
  assign word2_is_signed_and_negative = job_q.neg;
  assign dbg_state                    = state_q;

endmodule

// File: tb/tb_nibble_alu_arbiter.sv
// Directed bench for nibble_alu_arbiter with a behavioural nibble ALU stand-in.
module tb_nibble_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N_REQ   = 2;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0][WIDTH-1:0] req_w1, req_w2, req_preinit;
  logic [N_REQ-1:0][2:0]       req_nibbles;
  logic [N_REQ-1:0]            req_neg;
  logic [N_REQ-1:0]            gnt, done;
  logic [WIDTH-1:0]            result;
  logic                        err, alu_perm_to_count;
  logic [WIDTH-1:0]            alu_w1, alu_w2, alu_preinit_result;
  logic [2:0]                  loop_nibbles_number;
  logic                        word2_is_signed_and_negative;
  logic                        alu_busy;
  logic [WIDTH-1:0]            alu_result;
  ArbState                     dbg_state;

  nibble_alu_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk), .rst_n (rst_n), .req (req),
    .req_w1 (req_w1), .req_w2 (req_w2), .req_preinit (req_preinit),
    .req_nibbles (req_nibbles), .req_neg (req_neg),
    .gnt (gnt), .done (done), .result (result), .err (err),
    .alu_perm_to_count (alu_perm_to_count),
    .alu_w1 (alu_w1), .alu_w2 (alu_w2), .alu_preinit_result (alu_preinit_result),
    .loop_nibbles_number (loop_nibbles_number),
    .word2_is_signed_and_negative (word2_is_signed_and_negative),
    .alu_busy (alu_busy), .alu_result (alu_result), .dbg_state (dbg_state)
  );

  // ---------------- ALU stand-in ----------------
  // Starts when it sees permission, stays busy nibbles+1 cycles, then returns
  // w1 + w2 (or w1 - w2 when word2 is negative) using operands seen at start.
  logic             alu_zero_len = 1'b0;
  logic             alu_stuck = 1'b0;
  logic             alu_active;
  int               alu_cnt;
  logic [WIDTH-1:0] alu_acc;

  always @(posedge clk) begin
    if (!rst_n || !alu_perm_to_count) begin
      alu_active <= 1'b0;
      alu_busy   <= 1'b0;
      alu_cnt    <= 0;
    end else if (!alu_active) begin
      alu_active <= 1'b1;
      if (alu_zero_len) begin
        alu_busy   <= 1'b0;
        alu_result <= word2_is_signed_and_negative ? alu_w1 - alu_w2 : alu_w1 + alu_w2;
      end else begin
        alu_busy <= 1'b1;
        alu_acc  <= word2_is_signed_and_negative ? alu_w1 - alu_w2 : alu_w1 + alu_w2;
        alu_cnt  <= alu_stuck ? 100000 : int'(loop_nibbles_number) + 1;
      end
    end else if (alu_busy) begin
      if (alu_cnt == 1) begin
        alu_busy   <= 1'b0;
        alu_result <= alu_acc;
      end else begin
        alu_cnt <= alu_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [N_REQ-1:0] exp_own_q[$];

  always @(negedge clk) if (|done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_job(input int idx, input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2,
                         input logic [WIDTH-1:0] pre, input logic [2:0] nib, input logic neg);
    req_w1[idx]      = w1;
    req_w2[idx]      = w2;
    req_preinit[idx] = pre;
    req_nibbles[idx] = nib;
    req_neg[idx]     = neg;
  endtask

  // Waits for a done pulse; optionally checks frozen operands while granted and
  // perturbs requester 1 (new w1, req dropped) at cycle mut_cycle.
  task automatic wait_done(input int limit, input int mut_cycle, input logic watch,
                           input logic [WIDTH-1:0] w1_exp, input logic [WIDTH-1:0] w2_exp,
                           output int cycles);
    logic [WIDTH-1:0] e;
    logic [N_REQ-1:0] o;
    cycles = 0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (watch && gnt != '0) begin
        check_eq("frozen_w1", alu_w1, w1_exp);
        check_eq("frozen_w2", alu_w2, w2_exp);
      end
      if (cycles == mut_cycle) begin
        req_w1[1] = 32'h0000_0555;
        req[1]    = 1'b0;
      end
      if (|done) break;
    end
    check_eq("done_seen", 32'(|done), 32'd1);
    if ((|done) && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = exp_own_q.pop_front();
      check_eq("result", result, e);
      check_eq("done_owner", 32'(done), 32'(o));
      check_eq("gnt_at_done", 32'(gnt), 32'(o));
    end
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    int cyc;
    int dc0;
    req = '0; req_w1 = '0; req_w2 = '0; req_preinit = '0; req_nibbles = '0; req_neg = '0;

    // reset state
    do_reset();
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_perm", 32'(alu_perm_to_count), 32'd0);
    check_eq("rst_w1", alu_w1, 32'd0);
    check_eq("rst_pre", alu_preinit_result, 32'd0);

    // single req0 INCREMENT: 0xff + 4
    dc0 = done_cnt;
    set_job(0, 32'hff, 32'd4, 32'hff, NIB_INCREMENT, 1'b0);
    req = 2'b01;
    step(1);
    check_eq("launch_gnt", 32'(gnt), 32'h1);
    check_eq("launch_perm", 32'(alu_perm_to_count), 32'd1);
    check_eq("launch_state", 32'(dbg_state), 32'(LAUNCH));
    check_eq("launch_w1", alu_w1, 32'hff);
    check_eq("launch_w2", alu_w2, 32'd4);
    check_eq("launch_pre", alu_preinit_result, 32'hff);
    check_eq("launch_nib", 32'(loop_nibbles_number), 32'(NIB_INCREMENT));
    exp_q.push_back(32'h103); exp_own_q.push_back(2'b01);
    wait_done(30, -1, 1'b1, 32'hff, 32'd4, cyc);
    check_eq("incr_latency", cyc + 1, 32'd4);
    check_eq("done_perm_low", 32'(alu_perm_to_count), 32'd0);
    req = '0;
    step(1);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("result_held", result, 32'h103);
    check_eq("gnt_released", 32'(gnt), 32'd0);
    step(2);
    check_eq("incr_done_count", done_cnt - dc0, 32'd1);

    // simultaneous requests after reset: 0,1,0,1
    do_reset();
    set_job(0, 32'hff, 32'd4, 32'hff, NIB_INCREMENT, 1'b0);
    set_job(1, 32'd123, 32'h800, 32'd123, NIB_12, 1'b1);
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(32'h103);      exp_own_q.push_back(2'b01);
      exp_q.push_back(32'hFFFFF87B); exp_own_q.push_back(2'b10);
    end
    req = 2'b11;
    wait_done(30, -1, 1'b0, '0, '0, cyc);
    check_eq("rr_first_latency", cyc, 32'd4);
    for (int j = 0; j < 3; j++) wait_done(30, -1, 1'b0, '0, '0, cyc);
    req = '0;
    step(3);

    // req1 BITS_12 negative, w1 changed and req dropped mid-RUN
    dc0 = done_cnt;
    set_job(1, 32'd123, 32'h800, 32'd0, NIB_12, 1'b1);
    req = 2'b10;
    exp_q.push_back(32'hFFFFF87B); exp_own_q.push_back(2'b10);
    wait_done(30, 3, 1'b1, 32'd123, 32'h800, cyc);
    check_eq("neg_latency", cyc, 32'd6);
    step(4);
    check_eq("drop_done_once", done_cnt - dc0, 32'd1);
    check_eq("drop_idle", 32'(dbg_state), 32'(IDLE));

    // zero-length job: busy already low in first RUN cycle
    alu_zero_len = 1'b1;
    set_job(0, 32'd5, 32'd3, 32'd0, NIB_8, 1'b0);
    req = 2'b01;
    exp_q.push_back(32'd8); exp_own_q.push_back(2'b01);
    wait_done(30, -1, 1'b0, '0, '0, cyc);
    check_eq("zero_latency", cyc, 32'd3);
    req = '0;
    alu_zero_len = 1'b0;
    step(2);

    // watchdog: ALU never drops busy
    dc0 = done_cnt;
    alu_stuck = 1'b1;
    set_job(0, 32'd1, 32'd1, 32'd0, NIB_32, 1'b0);
    req = 2'b01;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      cyc++;
      if (err) break;
    end
    check_eq("wdog_err", 32'(err), 32'd1);
    check_eq("wdog_cycles", cyc, 32'd19);
    check_eq("wdog_perm", 32'(alu_perm_to_count), 32'd0);
    check_eq("wdog_gnt", 32'(gnt), 32'd0);
    check_eq("wdog_state", 32'(dbg_state), 32'(ERR));
    req = 2'b11;
    step(3);
    check_eq("err_sticky", 32'(err), 32'd1);
    check_eq("err_ignores_req", 32'(gnt), 32'd0);
    check_eq("wdog_no_done", done_cnt - dc0, 32'd0);
    req = '0;
    alu_stuck = 1'b0;
    do_reset();
    check_eq("err_cleared", 32'(err), 32'd0);
    check_eq("err_rst_state", 32'(dbg_state), 32'(IDLE));

    // reset during RUN, then the held request is served from scratch
    dc0 = done_cnt;
    set_job(0, 32'h1000, 32'h10, 32'd0, NIB_32, 1'b0);
    req = 2'b01;
    step(3);
    check_eq("midrun_perm", 32'(alu_perm_to_count), 32'd1);
    rst_n = 1'b0;
    step(1);
    check_eq("midrun_rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("midrun_rst_gnt", 32'(gnt), 32'd0);
    check_eq("midrun_rst_perm", 32'(alu_perm_to_count), 32'd0);
    check_eq("midrun_rst_w1", alu_w1, 32'd0);
    check_eq("midrun_rst_result", result, 32'd0);
    check_eq("midrun_no_done", done_cnt - dc0, 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(32'h1010); exp_own_q.push_back(2'b01);
    wait_done(40, -1, 1'b1, 32'h1000, 32'h10, cyc);
    check_eq("post_rst_latency", cyc, 32'd11);
    req = '0;
    step(2);
    check_eq("exp_q_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
